// File: rtl/mem_responder.sv
// Word-addressed instruction/data memory for the multicycle core. Serves one
// access at a time, adds a fixed number of wait states, and acks each access.
//
// state     | meaning
// S_IDLE    | ready; a request is captured on the next edge
// S_WAIT    | wait-state countdown; inputs ignored
// S_RESPOND | o_ack pulse; write commits at the end of this cycle
module mem_responder #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int ADDR_WIDTH_P  = 32,
  parameter int DEPTH_LOG2_P  = 8,
  parameter int WAIT_STATES_P = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH_P-1:0] i_addr,
  input  logic [DATA_WIDTH_P-1:0] i_wr_data,
  output logic                    o_busy,
  output logic                    o_ack,
  output logic                    o_err,
  output logic [DATA_WIDTH_P-1:0] o_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES_P > 0) ? 4'(WAIT_STATES_P - 1) : 4'd0;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH_P-1:0] addr_q;
  logic [DATA_WIDTH_P-1:0] data_q;
  logic                    wr_en_q;

  logic [DATA_WIDTH_P-1:0] mem [2**DEPTH_LOG2_P];

  logic [DEPTH_LOG2_P-1:0] idx_q;
  logic [DEPTH_LOG2_P-1:0] idx_in;
  logic                    mis_q;
  logic                    mis_in;
  logic                    addr_unused;

  assign idx_q  = addr_q[DEPTH_LOG2_P+1:2];
  assign idx_in = i_addr[DEPTH_LOG2_P+1:2];
  assign mis_q  = |addr_q[1:0];
  assign mis_in = |i_addr[1:0];
  // Upper address bits alias onto the array by design.
  assign addr_unused = ^{addr_q[ADDR_WIDTH_P-1:DEPTH_LOG2_P+2],
                         i_addr[ADDR_WIDTH_P-1:DEPTH_LOG2_P+2]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rd_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req) begin
            addr_q  <= i_addr;
            data_q  <= i_wr_data;
            wr_en_q <= i_wr_en;
            o_busy  <= 1'b1;
            if (WAIT_STATES_P > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              // Zero wait states: respond straight from the live request.
              state <= S_RESPOND;
              o_ack <= 1'b1;
              o_err <= mis_in;
              if (!i_wr_en && !mis_in) o_rd_data <= mem[idx_in];
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESPOND;
            o_ack <= 1'b1;
            o_err <= mis_q;
            if (!wr_en_q && !mis_q) o_rd_data <= mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          o_ack  <= 1'b0;
          o_err  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          o_ack  <= 1'b0;
          o_err  <= 1'b0;
        end
      endcase
    end
  end

  // Array is not reset; a reset on the RESPOND edge also kills the write.
  always_ff @(posedge clk) begin
    if (reset && state == S_RESPOND && wr_en_q && !mis_q) mem[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a wait-state instance and a zero-wait instance,
// checked every cycle against a transaction-timing model plus literal checks.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req   [2];
  logic        wr_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        busy_o [2];
  logic        ack_o  [2];
  logic        err_o  [2];
  logic [31:0] rd_o   [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES_P(2)) dut0 (
    .clk(clk), .reset(reset), .i_req(req[0]), .i_wr_en(wr_en[0]),
    .i_addr(addr[0]), .i_wr_data(wdata[0]), .o_busy(busy_o[0]),
    .o_ack(ack_o[0]), .o_err(err_o[0]), .o_rd_data(rd_o[0]));

  mem_responder #(.WAIT_STATES_P(0)) dut1 (
    .clk(clk), .reset(reset), .i_req(req[1]), .i_wr_en(wr_en[1]),
    .i_addr(addr[1]), .i_wr_data(wdata[1]), .o_busy(busy_o[1]),
    .o_ack(ack_o[1]), .o_err(err_o[1]), .o_rd_data(rd_o[1]));

  function automatic int wfor(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a transaction accepted at edge A is answered in the cycle after
  // edge A+W and retired (write committed) at edge A+W+1.
  int          edge_n = 0;
  bit          inflight [2];
  int          acc      [2];
  logic        cap_wr   [2];
  logic [31:0] cap_addr [2];
  logic [31:0] cap_data [2];
  logic        m_busy   [2];
  logic        m_ack    [2];
  logic        m_err    [2];
  logic [31:0] m_rd     [2];
  logic [31:0] mem_m    [2][256];

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        inflight[k] = 1'b0;
        m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = '0;
      end else begin
        if (inflight[k] && edge_n == acc[k] + wfor(k) + 1) begin
          if (cap_wr[k] && cap_addr[k][1:0] == 2'b00)
            mem_m[k][cap_addr[k][9:2]] = cap_data[k];
          inflight[k] = 1'b0;
          m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_err[k] = 1'b0;
        end else if (!inflight[k] && req[k]) begin
          inflight[k] = 1'b1;
          acc[k] = edge_n;
          cap_wr[k] = wr_en[k]; cap_addr[k] = addr[k]; cap_data[k] = wdata[k];
          m_busy[k] = 1'b1;
        end
        if (inflight[k] && edge_n == acc[k] + wfor(k)) begin
          m_ack[k] = 1'b1;
          m_err[k] = (cap_addr[k][1:0] != 2'b00);
          if (!m_err[k] && !cap_wr[k]) m_rd[k] = mem_m[k][cap_addr[k][9:2]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
        check($sformatf("ack%0d", k),  32'(ack_o[k]),  32'(m_ack[k]));
        check($sformatf("err%0d", k),  32'(err_o[k]),  32'(m_err[k]));
        check($sformatf("rd%0d", k),   rd_o[k],        m_rd[k]);
      end
    end
  end

  task automatic access(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic err,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    req[k] = 1'b1; wr_en[k] = wr; addr[k] = a; wdata[k] = d;
    lat = 0;
    @(negedge clk);
    req[k] = 1'b0;
    lat = 1;
    while (!ack_o[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack_o[k]) check("ack_timeout", 32'(ack_o[k]), 32'd1);
    err = err_o[k];
    rd  = rd_o[k];
  endtask

  logic        e;
  logic [31:0] r;
  int          lat;
  int          n_ack;
  int          last_c;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr_en[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rd", rd_o[0], 32'h0);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) access(0, 1'b1, 32'(i * 4), pre(i), e, r, lat);

    access(0, 1'b0, 32'h10, '0, e, r, lat);
    check("rd10_data", r, 32'hC0DE0404);
    check("rd10_err", 32'(e), 32'd0);
    check("rd10_latency", 32'(lat), 32'd3);
    check("model_rd10", m_rd[0], 32'hC0DE0404);

    access(0, 1'b1, 32'h20, 32'hDEADBEEF, e, r, lat);
    check("wr20_rd_hold", r, 32'hC0DE0404);
    access(0, 1'b0, 32'h20, '0, e, r, lat);
    check("rd20_new", r, 32'hDEADBEEF);

    access(0, 1'b0, 32'h22, '0, e, r, lat);
    check("rd22_err", 32'(e), 32'd1);
    check("rd22_hold", r, 32'hDEADBEEF);
    access(0, 1'b1, 32'h21, 32'h5555AAAA, e, r, lat);
    check("wr21_err", 32'(e), 32'd1);
    access(0, 1'b0, 32'h20, '0, e, r, lat);
    check("rd20_after_mis", r, 32'hDEADBEEF);

    // Second request pulsed mid-WAIT must be ignored.
    @(negedge clk);
    req[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h10;
    @(negedge clk);
    addr[0] = 32'h30;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    check("intrude_ack", 32'(ack_o[0]), 32'd1);
    check("intrude_rd", rd_o[0], 32'hC0DE0404);
    repeat (4) @(negedge clk);

    access(0, 1'b1, 32'h400, 32'h12345678, e, r, lat);
    access(0, 1'b0, 32'h000, '0, e, r, lat);
    check("alias_rd", r, 32'h12345678);

    // Reset during WAIT of a write abandons it.
    @(negedge clk);
    req[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hBAD0BAD0;
    @(negedge clk);
    req[0] = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_busy", 32'(busy_o[0]), 32'd0);
    check("rst_rd", rd_o[0], 32'h0);
    repeat (5) @(negedge clk);
    check("rst_no_ack", 32'(ack_o[0]), 32'd0);
    access(0, 1'b0, 32'h30, '0, e, r, lat);
    check("rd30_prior", r, 32'hC0DE0C0C);

    for (int i = 0; i < 4; i++) access(1, 1'b1, 32'(i * 4), pre(i), e, r, lat);
    access(1, 1'b0, 32'h8, '0, e, r, lat);
    check("w0_latency", 32'(lat), 32'd1);
    check("w0_rd8", r, 32'hC0DE0202);

    // Zero wait states, request held high: one ack every second cycle.
    @(negedge clk);
    req[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 32'h0;
    n_ack = 0;
    last_c = -1;
    for (int c = 0; c < 12 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack_o[1]) begin
        check($sformatf("b2b_rd%0d", n_ack), rd_o[1], pre(n_ack));
        n_ack++;
        last_c = c;
        if (n_ack == 4) req[1] = 1'b0;
        else addr[1] = 32'(n_ack * 4);
      end
    end
    req[1] = 1'b0;
    check("b2b_acks", 32'(n_ack), 32'd4);
    check("b2b_spacing", 32'(last_c), 32'd6);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory responder for the multicycle core.
- Services the single word-access requests that the core's FETCH, MEMREAD and MEMWRITE states issue.
- Holds a word-addressed storage array and inserts a configurable number of wait states.
- Returns each access through a one-cycle acknowledge, with an error flag for misaligned addresses.

Parameters:
- DATA_WIDTH_P, 32, width of data words and of o_rd_data / i_wr_data.
- ADDR_WIDTH_P, 32, byte address width.
- DEPTH_LOG2_P, 8, log2 of the number of words in the array (256 words).
- WAIT_STATES_P, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- i_req  input  1  access request; sampled only in IDLE.
- i_wr_en  input  1  1 = write, 0 = read; captured at acceptance.
- i_addr  input  ADDR_WIDTH_P  byte address; captured at acceptance.
- i_wr_data  input  DATA_WIDTH_P  write data; captured at acceptance.
- o_busy  output  1  high while a transaction is in flight (WAIT or RESPOND).
- o_ack  output  1  one-cycle pulse marking transaction completion.
- o_err  output  1  valid with o_ack; 1 = misaligned address, access suppressed.
- o_rd_data  output  DATA_WIDTH_P  read data, registered.

Behaviour:
- Reset: reset==0 at a clk edge forces the following values.
  - FSM to IDLE, wait counter to 0.
  - o_busy=0, o_ack=0, o_err=0, o_rd_data=0.
  - Captured address, data and wr_en registers are cleared.
  - Array contents are not reset.
- FSM states are IDLE, WAIT and RESPOND.
- IDLE:
  - o_busy=0.
  - If i_req=1, capture i_addr, i_wr_en and i_wr_data.
  - Next state is WAIT if WAIT_STATES_P>0 (counter loaded with WAIT_STATES_P-1), else RESPOND.
  - If i_req=0, stay in IDLE.
- WAIT:
  - o_busy=1; inputs are ignored.
  - The counter decrements each cycle; at 0, go to RESPOND.
- RESPOND:
  - o_busy=1 and o_ack=1 for exactly this cycle; next state is IDLE.
  - Misaligned (captured addr[1:0]!=0): o_err=1, no array write, o_rd_data unchanged.
  - Aligned write: array[word index] <= captured data at the end of this cycle; o_err=0; o_rd_data unchanged.
  - Aligned read: o_rd_data shows array[word index] during this cycle, registered on entry to RESPOND; o_err=0.
- Word index is captured addr[DEPTH_LOG2_P+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2_P bytes with no error.
- Latency: for a request accepted at edge N, o_ack is high in cycle N+WAIT_STATES_P+1. Per-request throughput is one transaction per WAIT_STATES_P+2 cycles.
- o_rd_data holds its value until the next successful read, so the core may sample it in any later state.
- o_ack and o_err are 0 in every state except RESPOND.
- i_req held high through IDLE after a RESPOND is accepted as a new transaction. Requesters must drop i_req by the cycle following o_ack.
- Write then immediate read of the same word returns the new data, because the write commits before the read can be accepted.
- Reset mid-transaction (WAIT or RESPOND): the transaction is abandoned, no ack is issued and no write occurs. If reset coincides with the RESPOND edge, the write is also suppressed.
- WAIT_STATES_P=0: RESPOND immediately follows the acceptance edge and the WAIT state is never entered.

Test Plan:
- Reset with array preloaded; read addr 0x10 at WAIT_STATES_P=2 -> o_ack high exactly 3 cycles after the accept edge, o_rd_data=preload[4], o_err=0, o_busy high for 3 cycles.
- Write 0xDEADBEEF to 0x20, then read 0x20 -> write ack with o_rd_data unchanged; read ack returns 0xDEADBEEF.
- Read 0x22 (misaligned) -> o_ack with o_err=1, o_rd_data unchanged. Misaligned write to 0x21 followed by an aligned read of 0x20 shows the array unchanged.
- Pulse i_req during WAIT with a different address -> ignored; the single ack reflects the original address. Aliasing: write to 0x400 then read 0x000 -> same word returned (DEPTH_LOG2_P=8).
- Assert reset=0 for one cycle during WAIT of a write to 0x30 -> no ack, outputs cleared, a later read of 0x30 returns the prior contents.
- Rebuild with WAIT_STATES_P=0; back-to-back reads with i_req held continuously -> acks every 2nd cycle, each with the correct data.
